// File: rtl/mul16_arbiter_if.sv
// Purpose: request/response bundle between the multiply clients and the shared multiplier.
// Latency: none, this is wiring only.
// Backpressure: req_ready grants one requester; rsp_ready stalls the single response channel.
// Ports: slave = arbiter side, master = client side.
//   req_valid/req_a/req_b  per-requester strobe and packed 16-bit operands (slice i = [16*i+15:16*i])
//   req_ready              one-hot grant
//   rsp_valid/rsp_id/rsp_prod/rsp_ready  tagged 32-bit product
//   busy                   arbiter not idle
interface mul16_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_prod;
  logic                  rsp_ready;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );
endinterface

// File: rtl/mul16_arbiter.sv
// Purpose: round-robin share of one registered 16x16 unsigned multiplier among NUM_REQ clients.
// Latency: grant in cycle T, rsp_valid in cycle T+2; at most one product every 3 cycles.
// Backpressure: rsp_ready low holds the response stable; no new grant until it is consumed.
// Ports: clk, rst_n (async active-low); bus = mul16_arbiter_if.slave (request and response channels, busy).

// Plain combinational 16x16 unsigned multiplier.
module mul16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  assign o_p = {16'h0000, i_a} * {16'h0000, i_b};
endmodule

module mul16_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mul16_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [15:0]        r_op_a;
  logic [15:0]        r_op_b;
  logic [ID_W-1:0]    r_id;
  logic               r_rsp_vld;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_prod;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic [ID_W-1:0]    w_gidx;
  logic [ID_W-1:0]    w_nxt_ptr;
  logic [ID_W:0]      w_idx;
  logic [15:0]        w_sel_a;
  logic [15:0]        w_sel_b;
  logic [31:0]        w_prod;

  // Round-robin pick: scan from r_rr_ptr upward, wrapping, first valid wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_found                   = 1'b1;
        w_gidx                    = w_idx[ID_W-1:0];
        w_grant[w_idx[ID_W-1:0]]  = 1'b1;
        w_sel_a = bus.req_a[{w_idx[ID_W-1:0], 4'b0000} +: 16];
        w_sel_b = bus.req_b[{w_idx[ID_W-1:0], 4'b0000} +: 16];
      end
    end
  end

  assign w_nxt_ptr = (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;

  mul16 u_mul16 (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  // Grant is combinational but must read zero the instant reset is applied,
  // so it is qualified by rst_n as well as by the idle state.
  assign bus.req_ready = (rst_n && (r_state == S_IDLE)) ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_prod  = r_rsp_prod;
  assign bus.busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_id       <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_prod <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // w_found in idle is exactly a handshake: the grant only ever selects a valid requester.
          if (w_found) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_id     <= w_gidx;
            r_rr_ptr <= w_nxt_ptr;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_rsp_prod <= w_prod;
          r_rsp_id   <= r_id;
          r_rsp_vld  <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          // Product and tag are left in place after the handshake; only valid drops.
          if (bus.rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_arbiter.sv
// Purpose: directed self-checking bench for mul16_arbiter.
// Latency: checks grant at T, response at T+2, next grant at T+3.
// Backpressure: holds rsp_ready low for several cycles and checks the response is frozen.
module tb_mul16_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mul16_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  mul16_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  // Full transaction with rsp_ready high, started in an idle cycle with requests already driven.
  task automatic serve(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_id,
                       input logic [31:0] exp_prod, input logic [3:0] nxt_vld);
    #1;
    chk({tag, ".grant"}, 32'(bus.req_ready), 32'(exp_rdy));
    step();
    bus.req_valid = nxt_vld;
    #1;
    chk({tag, ".mul_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".mul_vld"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".mul_rdy"}, 32'(bus.req_ready), 32'd0);
    step();
    chk({tag, ".rsp_vld"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({tag, ".rsp_prod"}, bus.rsp_prod, exp_prod);
    step();
    chk({tag, ".vld_clr"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [31:0] rr_prod [5];
  logic [1:0]  rr_id   [5];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rr_prod = '{32'd14, 32'h0001_0000, 32'h0000_FFFF, 32'h0001_FFFE, 32'd14};
    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state, with requests present to show the grant is held off.
    #3;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst.rsp_prod", bus.rsp_prod, 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    step();
    bus.req_valid = 4'h0;
    rst_n = 1'b1;
    step();
    #1;
    chk("idle.busy", 32'(bus.busy), 32'd0);
    chk("idle.req_ready", 32'(bus.req_ready), 32'd0);

    // Single request from requester 2: 3*5.
    step();
    set_op(2, 16'd3, 16'd5);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    serve("single", 4'b0100, 2'd2, 32'd15, 4'b0000);
    chk("single.prod_kept", bus.rsp_prod, 32'd15);
    chk("single.idle_busy", 32'(bus.busy), 32'd0);

    // Largest operands through requester 3 (pointer now 3).
    set_op(3, 16'hFFFF, 16'hFFFF);
    bus.req_valid = 4'b1000;
    serve("max", 4'b1000, 2'd3, 32'hFFFE_0001, 4'b0000);

    // Round robin with everyone requesting; pointer now 0.
    set_op(0, 16'h0002, 16'h0007);
    set_op(1, 16'h0100, 16'h0100);
    set_op(2, 16'h00FF, 16'h0101);
    set_op(3, 16'hFFFF, 16'h0002);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      serve($sformatf("rr%0d", k), 4'(1 << rr_id[k]), rr_id[k], rr_prod[k],
            (k == 4) ? 4'h0 : 4'hF);
    end

    // Pointer is 1 and only 0 and 3 request: 3 wins, then 0.
    bus.req_valid = 4'b1001;
    serve("skip_a", 4'b1000, 2'd3, 32'h0001_FFFE, 4'b1001);
    serve("skip_b", 4'b0001, 2'd0, 32'd14, 4'b0000);

    // Zero operand through requester 1 (pointer now 1).
    set_op(1, 16'h1234, 16'h0000);
    bus.req_valid = 4'b0010;
    serve("zero", 4'b0010, 2'd1, 32'd0, 4'b0000);

    // Idle cycles must not move the pointer (still 2).
    step();
    step();
    set_op(2, 16'h1234, 16'h0010);
    bus.req_valid = 4'b1100;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp.grant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = 4'b1000;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.vld", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d.id", c), 32'(bus.rsp_id), 32'd2);
      chk($sformatf("bp%0d.prod", c), bus.rsp_prod, 32'h0001_2340);
      chk($sformatf("bp%0d.rdy", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("bp%0d.busy", c), 32'(bus.busy), 32'd1);
      if (c < 4) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp.vld_clr", 32'(bus.rsp_valid), 32'd0);
    chk("bp.next_grant", 32'(bus.req_ready), 32'b1000);
    chk("bp.prod_kept", bus.rsp_prod, 32'h0001_2340);

    // Requester 3 is now in MUL; reset it away.
    step();
    bus.req_valid = 4'hF;
    #1;
    chk("rstmid.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid.busy", 32'(bus.busy), 32'd0);
    chk("rstmid.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rstmid.rsp_prod", bus.rsp_prod, 32'd0);
    step();
    chk("rstmid.held_vld", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rstmid.first_grant", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = 4'h0;
    #1;
    chk("rstmid.no_stale", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("rstmid.rsp_vld", 32'(bus.rsp_valid), 32'd1);
    chk("rstmid.rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rstmid.rsp_prod", bus.rsp_prod, 32'd14);
    step();
    chk("rstmid.vld_clr", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
